alu_uart_host: RTL

- Initiator (host) end of the UART byte protocol our ALU responder speaks.
- Accepts an operand pair plus opcode on a start pulse.
- Drives a UART transmitter to send A, then B, then OPCODE, then waits for the single result byte from the UART receiver.
- Used as the loopback/self-test host and as the command source in board-level benches.

---
 rtl/alu_uart_host.sv | 139 +++++++++++++
 1 files changed

// File: rtl/alu_uart_host.sv
// Host end of the ALU UART byte protocol: sends A, B, {0,opcode} and then waits for one result byte.
// Latency: the first tx_start follows the accepting edge; the result or timeout is reported one edge after rx or expiry.
// Backpressure: each byte waits for tx_done_tick, and start is ignored while busy; the result wait is bounded by TIMEOUT_CYCLES.
module alu_uart_host #(
    parameter int NBIT_DATA_LEN  = 8,
    parameter int NBIT_OPCODE    = 6,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     start,
    input  logic [NBIT_DATA_LEN-1:0] a_in,
    input  logic [NBIT_DATA_LEN-1:0] b_in,
    input  logic [NBIT_OPCODE-1:0]   opcode_in,
    output logic                     tx_start,
    output logic [NBIT_DATA_LEN-1:0] tx_data,
    input  logic                     tx_done_tick,
    input  logic                     rx_done_tick,
    input  logic [NBIT_DATA_LEN-1:0] rx_data,
    output logic                     busy,
    output logic [NBIT_DATA_LEN-1:0] result,
    output logic                     done,
    output logic                     timeout
);

    // Last counter value before the response wait gives up.
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE, SEND_A, WAIT_A, SEND_B, WAIT_B, SEND_OP, WAIT_OP, WAIT_RES
    } state_t;

    state_t                   state, state_nxt;
    logic [NBIT_DATA_LEN-1:0] b_q, b_nxt;
    logic [NBIT_OPCODE-1:0]   op_q, op_nxt;
    logic [31:0]              cnt, cnt_nxt;

    logic                     tx_start_nxt;
    logic [NBIT_DATA_LEN-1:0] tx_data_nxt;
    logic                     busy_nxt;
    logic [NBIT_DATA_LEN-1:0] result_nxt;
    logic                     done_nxt;
    logic                     timeout_nxt;

    // Register the state, the captured operands and every output. Reset clears all of them.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= IDLE;
            b_q      <= '0;
            op_q     <= '0;
            cnt      <= '0;
            tx_start <= 1'b0;
            tx_data  <= '0;
            busy     <= 1'b0;
            result   <= '0;
            done     <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            state    <= state_nxt;
            b_q      <= b_nxt;
            op_q     <= op_nxt;
            cnt      <= cnt_nxt;
            tx_start <= tx_start_nxt;
            tx_data  <= tx_data_nxt;
            busy     <= busy_nxt;
            result   <= result_nxt;
            done     <= done_nxt;
            timeout  <= timeout_nxt;
        end
    end

    // Compute the next state and the next output values. tx_start rises on entry to each SEND state,
    // so it is high only for the single cycle spent in that state.
    always_comb begin
        state_nxt    = state;
        b_nxt        = b_q;
        op_nxt       = op_q;
        cnt_nxt      = cnt;
        tx_start_nxt = 1'b0;
        tx_data_nxt  = tx_data;
        busy_nxt     = busy;
        result_nxt   = result;
        done_nxt     = 1'b0;
        timeout_nxt  = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    // Operand A goes straight to the wire. B and the opcode are held for later.
                    b_nxt        = b_in;
                    op_nxt       = opcode_in;
                    tx_data_nxt  = a_in;
                    tx_start_nxt = 1'b1;
                    busy_nxt     = 1'b1;
                    state_nxt    = SEND_A;
                end
            end
            SEND_A: state_nxt = WAIT_A;
            WAIT_A: begin
                if (tx_done_tick) begin
                    tx_data_nxt  = b_q;
                    tx_start_nxt = 1'b1;
                    state_nxt    = SEND_B;
                end
            end
            SEND_B: state_nxt = WAIT_B;
            WAIT_B: begin
                if (tx_done_tick) begin
                    tx_data_nxt  = NBIT_DATA_LEN'(op_q);
                    tx_start_nxt = 1'b1;
                    state_nxt    = SEND_OP;
                end
            end
            SEND_OP: state_nxt = WAIT_OP;
            WAIT_OP: begin
                if (tx_done_tick) begin
                    cnt_nxt   = '0;
                    state_nxt = WAIT_RES;
                end
            end
            WAIT_RES: begin
                cnt_nxt = cnt + 32'd1;
                // A byte that arrives on the expiry cycle still counts as a valid result.
                if (rx_done_tick) begin
                    result_nxt = rx_data;
                    done_nxt   = 1'b1;
                    busy_nxt   = 1'b0;
                    state_nxt  = IDLE;
                end else if (cnt == TMO_LAST) begin
                    timeout_nxt = 1'b1;
                    busy_nxt    = 1'b0;
                    state_nxt   = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
